data_ram: RTL and testbench

- Byte-addressed, little-endian data memory for the RISC-V core's load/store unit.
- Supports byte, half and word accesses, with sign/zero extension on loads.
- Uses a valid/ready request channel and a response after a parametrised latency.
- Keeps one transaction outstanding, with range checking and an error flag in the response.

---
 rtl/data_ram_if.sv | 23 ++
 rtl/data_ram.sv | 122 ++++++++++++
 tb/tb_data_ram.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/data_ram_if.sv
// Request/response bundle between a load/store unit and data_ram.
interface data_ram_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_base;
  logic [31:0] req_offset;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_base, req_offset, req_size, req_unsigned, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_base, req_offset, req_size, req_unsigned, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_ram.sv
// Byte-addressed little-endian data memory, one outstanding access, fixed response latency.
// Define DATA_RAM_MISALIGN_CHK_EN to flag misaligned half/word accesses as errors.
module data_ram #(
  parameter int DEPTH_BYTES = 4096,
  parameter int LATENCY     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  data_ram_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] data_q;
  logic        err_q;

  logic [7:0]  mem [DEPTH_BYTES];

  logic [31:0] addr;
  logic [32:0] last;
  logic [1:0]  nm1;
  logic        range_err, size_err, mis_err, err, accept;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [7:0]  b0, b1, b2, b3;
  logic [31:0] ld, rdata_nxt;

  assign addr = bus.req_base + bus.req_offset;

  always_comb begin
    nm1 = 2'd0;
    case (bus.req_size)
      2'd1:    nm1 = 2'd1;
      2'd2:    nm1 = 2'd3;
      default: nm1 = 2'd0;
    endcase
  end

  // Last byte computed in 33 bits so an access straddling 2^32 cannot look in range.
  assign last      = {1'b0, addr} + 33'(nm1);
  assign range_err = last >= 33'(DEPTH_BYTES);
  assign size_err  = bus.req_size == 2'd3;
`ifdef DATA_RAM_MISALIGN_CHK_EN
  assign mis_err = ((bus.req_size == 2'd1) && addr[0]) ||
                   ((bus.req_size == 2'd2) && (addr[1:0] != 2'b00));
`else
  assign mis_err = 1'b0;
`endif
  assign err    = range_err || size_err || mis_err;
  assign accept = bus.req_valid && (state_q == S_IDLE);

  assign a0 = addr[AW-1:0];
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  always_comb begin
    ld = {b3, b2, b1, b0};
    case (bus.req_size)
      2'd0: ld = bus.req_unsigned ? {24'd0, b0} : {{24{b0[7]}}, b0};
      2'd1: ld = bus.req_unsigned ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: ld = {b3, b2, b1, b0};
    endcase
  end

  assign rdata_nxt = (bus.req_we || err) ? 32'd0 : ld;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_WAIT;
        cnt_d   = 2'(LATENCY - 1);
      end
      S_WAIT: begin
        if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
        else               state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        data_q <= rdata_nxt;
        err_q  <= err;
      end
    end
  end

  // Array is deliberately outside reset: committed stores survive rst_n.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !err) begin
      mem[a0] <= bus.req_wdata[7:0];
      if (bus.req_size != 2'd0) mem[a1] <= bus.req_wdata[15:8];
      if (bus.req_size == 2'd2) begin
        mem[a2] <= bus.req_wdata[23:16];
        mem[a3] <= bus.req_wdata[31:24];
      end
    end
  end

  assign bus.req_ready = state_q == S_IDLE;
  assign bus.rsp_valid = (state_q == S_WAIT) && (cnt_q == 2'd0);
  assign bus.rsp_rdata = bus.rsp_valid ? data_q : 32'd0;
  assign bus.rsp_err   = bus.rsp_valid && err_q;
endmodule

// File: tb/tb_data_ram.sv
// Directed bench for data_ram: three instances at LATENCY 1/2/3 share one request bus.
module tb_data_ram;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        vld [3];
  logic        s_we, s_uns;
  logic [31:0] s_base, s_off, s_wd;
  logic [1:0]  s_sz;
  logic        rdy [3];
  logic        rv  [3];
  logic        er  [3];
  logic [31:0] rd  [3];

  data_ram_if if0 ();
  data_ram_if if1 ();
  data_ram_if if2 ();

  data_ram #(.DEPTH_BYTES(4096), .LATENCY(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  data_ram #(.DEPTH_BYTES(4096), .LATENCY(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  data_ram #(.DEPTH_BYTES(4096), .LATENCY(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.req_valid = vld[0];
  assign if1.req_valid = vld[1];
  assign if2.req_valid = vld[2];
  assign {if0.req_we, if1.req_we, if2.req_we} = {3{s_we}};
  assign {if0.req_unsigned, if1.req_unsigned, if2.req_unsigned} = {3{s_uns}};
  assign {if0.req_size, if1.req_size, if2.req_size} = {3{s_sz}};
  assign if0.req_base = s_base;
  assign if1.req_base = s_base;
  assign if2.req_base = s_base;
  assign if0.req_offset = s_off;
  assign if1.req_offset = s_off;
  assign if2.req_offset = s_off;
  assign if0.req_wdata = s_wd;
  assign if1.req_wdata = s_wd;
  assign if2.req_wdata = s_wd;
  assign rdy[0] = if0.req_ready;
  assign rdy[1] = if1.req_ready;
  assign rdy[2] = if2.req_ready;
  assign rv[0] = if0.rsp_valid;
  assign rv[1] = if1.rsp_valid;
  assign rv[2] = if2.rsp_valid;
  assign rd[0] = if0.rsp_rdata;
  assign rd[1] = if1.rsp_rdata;
  assign rd[2] = if2.rsp_rdata;
  assign er[0] = if0.rsp_err;
  assign er[1] = if1.rsp_err;
  assign er[2] = if2.rsp_err;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request on instance sel; returns response data/err and latency in cycles.
  task automatic xact(input int sel, input logic we, input logic [31:0] base, input logic [31:0] off,
                      input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    s_we = we; s_base = base; s_off = off; s_sz = sz; s_uns = uns; s_wd = wd;
    vld[sel] = 1'b1;
    n = 0;
    while (!rdy[sel] && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 vld[sel] = 1'b0;
    lat = 0; rdata = '0; err = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rv[sel]) begin rdata = rd[sel]; err = er[sel]; break; end
    end
    if (lat >= 20) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] r;
  logic        e;
  int          l;

  initial begin
    for (int i = 0; i < 3; i++) vld[i] = 1'b0;
    s_we = 0; s_uns = 0; s_base = 0; s_off = 0; s_sz = 0; s_wd = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(rdy[0]), 32'd1);
    chk("rst_rvalid", 32'(rv[0]), 32'd0);
    chk("rst_rdata", rd[0], 32'd0);
    chk("rst_err", 32'(er[0]), 32'd0);
    rst_n = 1'b1;

    xact(0, 1, 32'h100, 0, 2'd2, 0, 32'hDEADBEEF, r, e, l);
    chk("sw_rdata", r, 32'd0); chk("sw_err", 32'(e), 0); chk("sw_lat1", 32'(l), 1);
    xact(0, 0, 32'h100, 0, 2'd2, 0, 0, r, e, l);
    chk("lw_rdata", r, 32'hDEADBEEF); chk("lw_err", 32'(e), 0); chk("lw_lat1", 32'(l), 1);
    @(negedge clk);
    chk("rdata_clear", rd[0], 32'd0);

    xact(0, 0, 32'h100, 0, 2'd0, 0, 0, r, e, l); chk("lb", r, 32'hFFFFFFEF);
    xact(0, 0, 32'h100, 0, 2'd0, 1, 0, r, e, l); chk("lbu", r, 32'h000000EF);
    xact(0, 0, 32'h100, 2, 2'd1, 0, 0, r, e, l); chk("lh", r, 32'hFFFFDEAD);
    xact(0, 0, 32'h100, 2, 2'd1, 1, 0, r, e, l); chk("lhu", r, 32'h0000DEAD);
    xact(0, 0, 32'h104, 32'hFFFFFFFC, 2'd0, 1, 0, r, e, l); chk("neg_off", r, 32'h000000EF);

    xact(0, 1, 32'h101, 0, 2'd0, 0, 32'h12345677, r, e, l);
    xact(0, 0, 32'h100, 0, 2'd2, 0, 0, r, e, l); chk("sb_merge", r, 32'hDEAD77EF);

    xact(0, 0, 32'h101, 0, 2'd1, 0, 0, r, e, l);
`ifdef DATA_RAM_MISALIGN_CHK_EN
    chk("mis_lh_err", 32'(e), 1); chk("mis_lh_rdata", r, 32'd0);
`else
    chk("mis_lh_err", 32'(e), 0); chk("mis_lh_rdata", r, 32'hFFFFAD77);
`endif

    xact(0, 1, 32'd4092, 0, 2'd2, 0, 32'hA5A5A5A5, r, e, l); chk("sw_4092_err", 32'(e), 0);
    xact(0, 1, 32'd4094, 0, 2'd2, 0, 32'h11223344, r, e, l); chk("sw_4094_err", 32'(e), 1);
    xact(0, 0, 32'd4092, 0, 2'd2, 0, 0, r, e, l); chk("top_unchanged", r, 32'hA5A5A5A5);
    xact(0, 0, 32'd4096, 0, 2'd0, 0, 0, r, e, l);
    chk("lb_4096_err", 32'(e), 1); chk("lb_4096_rdata", r, 32'd0);

    xact(0, 1, 32'd0, 0, 2'd2, 0, 32'hCAFEF00D, r, e, l);
    xact(0, 0, 32'hFFFFFFFC, 4, 2'd2, 0, 0, r, e, l);
    chk("wrap_err", 32'(e), 0); chk("wrap_rdata", r, 32'hCAFEF00D);
    xact(0, 0, 32'hFFFFFFFF, 1, 2'd0, 0, 0, r, e, l); chk("wrap_lb", r, 32'h0000000D);
    xact(0, 0, 32'hFFFFFFFF, 0, 2'd0, 0, 0, r, e, l); chk("hi_addr_err", 32'(e), 1);

    xact(0, 0, 32'd0, 0, 2'd3, 0, 0, r, e, l);
    chk("size3_err", 32'(e), 1); chk("size3_rdata", r, 32'd0);
    xact(0, 1, 32'd0, 0, 2'd3, 0, 32'hFFFFFFFF, r, e, l);
    xact(0, 0, 32'd0, 0, 2'd2, 0, 0, r, e, l); chk("size3_no_write", r, 32'hCAFEF00D);

    xact(2, 1, 32'h100, 0, 2'd2, 0, 32'hDEADBEEF, r, e, l); chk("sw_lat3", 32'(l), 3);
    xact(2, 0, 32'h100, 0, 2'd2, 0, 0, r, e, l);
    chk("lw_lat3", 32'(l), 3); chk("lw3_rdata", r, 32'hDEADBEEF);

    // Continuous valid at LATENCY=2: ready/valid repeat with period 3.
    @(negedge clk);
    s_we = 0; s_base = 0; s_off = 0; s_sz = 2'd2; s_uns = 0;
    vld[1] = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("b2b_ready%0d", k), 32'(rdy[1]), (k % 3 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_rvalid%0d", k), 32'(rv[1]), (k % 3 == 2) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    vld[1] = 1'b0;
    repeat (2) @(negedge clk);

    // Reset during WAIT after an accepted store on the LATENCY=3 instance.
    s_we = 1; s_base = 32'h200; s_off = 0; s_sz = 2'd2; s_wd = 32'h5A5A1234;
    vld[2] = 1'b1;
    @(posedge clk);
    #1 vld[2] = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rst_no_rsp%0d", k), 32'(rv[2]), 32'd0);
    end
    rst_n = 1'b1;
    xact(2, 0, 32'h200, 0, 2'd2, 0, 0, r, e, l);
    chk("rst_commit", r, 32'h5A5A1234); chk("rst_commit_err", 32'(e), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
